// File: rtl/ddr3_bringup_sequencer.sv
// DDR3 EMIF bring-up sequencer: POR hold, lock/calibration wait with timeout, bounded retries, staggered downstream resets.
// Define DDR3_BRINGUP_FAIL_CAUSE_EN to add the o_fail_cause output.
module ddr3_bringup_sequencer #(
   parameter int POR_CYCLES  = 10,
   parameter int CAL_TIMEOUT = 2000000,
   parameter int MAX_RETRIES = 3,
   parameter int N_STAGES    = 2,
   parameter int STAGE_GAP   = 16
) (
   input  logic                               i_rclk,
   input  logic                               i_reset_n,
   input  logic                               i_pll_locked,
   input  logic                               i_init_done,
   input  logic                               i_cal_success,
   input  logic                               i_cal_fail,
   input  logic                               i_rearm,
   output logic                               o_emif_reset_n,
   output logic [N_STAGES-1:0]                o_stage_reset_n,
   output logic                               o_ready,
   output logic                               o_error,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
   output logic [2:0]                         o_state
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
   ,
   output logic [1:0]                         o_fail_cause
`endif
);

   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int PW = $clog2(POR_CYCLES + 1);
   localparam int TW = $clog2(CAL_TIMEOUT + 1);
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   typedef enum logic [2:0] {
      ST_POR       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_WAIT_CAL  = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5,
      ST_ERROR     = 3'd6
   } state_t;

   state_t              r_state;
   logic [PW-1:0]       r_porCnt;
   logic [TW-1:0]       r_toCnt;
   logic [GW-1:0]       r_gapCnt;
   logic [SW-1:0]       r_stageIdx;
   logic [RW-1:0]       r_retryCnt;
   logic                r_emifResetN;
   logic [N_STAGES-1:0] r_stageResetN;
   logic                r_ready;
   logic                r_error;
   logic [3:0]          r_syncMeta;
   logic [3:0]          r_syncOut;

   logic          w_lockS;
   logic          w_initS;
   logic          w_calOkS;
   logic          w_calFailS;
   logic          w_timeout;
   logic [TW-1:0] w_toNext;
   logic          w_failReq;
   logic [1:0]    w_failCause;

   assign w_lockS    = r_syncOut[0];
   assign w_initS    = r_syncOut[1];
   assign w_calOkS   = r_syncOut[2];
   assign w_calFailS = r_syncOut[3];

   // Timeout fires on the edge where the per-attempt count would reach CAL_TIMEOUT; the count saturates.
   assign w_timeout = (r_toCnt >= TW'(CAL_TIMEOUT - 1));
   assign w_toNext  = (r_toCnt == TW'(CAL_TIMEOUT)) ? r_toCnt : r_toCnt + 1'b1;

   // Two-flop synchronisers for the EMIF status inputs, which are asynchronous to rclk.
   always_ff @(posedge i_rclk) begin
      if (!i_reset_n) begin
         r_syncMeta <= '0;
         r_syncOut  <= '0;
      end else begin
         r_syncMeta <= {i_cal_fail, i_cal_success, i_init_done, i_pll_locked};
         r_syncOut  <= r_syncMeta;
      end
   end

   // Failure detection per state; cause priority is cal_fail, then lock lost, then timeout.
   always_comb begin
      w_failReq   = 1'b0;
      w_failCause = 2'd0;
      case (r_state)
         ST_WAIT_LOCK: begin
            if (w_timeout) begin
               w_failReq   = 1'b1;
               w_failCause = 2'd1;
            end
         end
         ST_WAIT_CAL: begin
            if (w_calFailS) begin
               w_failReq   = 1'b1;
               w_failCause = 2'd2;
            end else if (!w_lockS) begin
               w_failReq   = 1'b1;
               w_failCause = 2'd3;
            end else if (w_timeout) begin
               w_failReq   = 1'b1;
               w_failCause = 2'd1;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (w_calFailS) begin
               w_failReq   = 1'b1;
               w_failCause = 2'd2;
            end else if (!w_lockS) begin
               w_failReq   = 1'b1;
               w_failCause = 2'd3;
            end
         end
         default: ;
      endcase
   end

`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
   logic [1:0] r_failCause;
   assign o_fail_cause = r_failCause;
`else
   logic w_unusedCause;
   assign w_unusedCause = ^w_failCause;
`endif

   // Bring-up FSM; every output is registered alongside the state.
   always_ff @(posedge i_rclk) begin
      if (!i_reset_n) begin
         r_state       <= ST_POR;
         r_porCnt      <= '0;
         r_toCnt       <= '0;
         r_gapCnt      <= '0;
         r_stageIdx    <= '0;
         r_retryCnt    <= '0;
         r_emifResetN  <= 1'b0;
         r_stageResetN <= '0;
         r_ready       <= 1'b0;
         r_error       <= 1'b0;
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
         r_failCause   <= 2'd0;
`endif
      end else if (w_failReq) begin
         r_state       <= ST_FAIL;
         r_emifResetN  <= 1'b0;
         r_stageResetN <= '0;
         r_ready       <= 1'b0;
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
         r_failCause   <= w_failCause;
`endif
      end else begin
         case (r_state)
            ST_POR: begin
               r_toCnt <= '0;
               if (r_porCnt == PW'(POR_CYCLES - 1)) begin
                  r_porCnt     <= '0;
                  r_emifResetN <= 1'b1;
                  r_state      <= ST_WAIT_LOCK;
               end else begin
                  r_porCnt <= r_porCnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               r_toCnt <= w_toNext;
               if (w_lockS) begin
                  r_state <= ST_WAIT_CAL;
               end
            end
            ST_WAIT_CAL: begin
               r_toCnt <= w_toNext;
               if (w_initS && w_calOkS) begin
                  r_state    <= ST_RELEASE;
                  r_gapCnt   <= '0;
                  r_stageIdx <= '0;
               end
            end
            ST_RELEASE: begin
               // The gap counter runs down so the next stage is released whenever it reads zero.
               if (r_gapCnt == '0) begin
                  r_stageResetN[r_stageIdx] <= 1'b1;
                  r_gapCnt                  <= GW'(STAGE_GAP - 1);
                  if (r_stageIdx == SW'(N_STAGES - 1)) begin
                     r_state <= ST_RUN;
                     r_ready <= 1'b1;
                  end else begin
                     r_stageIdx <= r_stageIdx + 1'b1;
                  end
               end else begin
                  r_gapCnt <= r_gapCnt - 1'b1;
               end
            end
            ST_RUN: ;
            ST_FAIL: begin
               r_porCnt <= '0;
               if (r_retryCnt < RW'(MAX_RETRIES)) begin
                  r_retryCnt <= r_retryCnt + 1'b1;
                  r_state    <= ST_POR;
               end else begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
               end
            end
            ST_ERROR: begin
               if (i_rearm) begin
                  r_retryCnt <= '0;
                  r_error    <= 1'b0;
                  r_porCnt   <= '0;
                  r_state    <= ST_POR;
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
                  r_failCause <= 2'd0;
`endif
               end
            end
            default: r_state <= ST_POR;
         endcase
      end
   end

   assign o_emif_reset_n  = r_emifResetN;
   assign o_stage_reset_n = r_stageResetN;
   assign o_ready         = r_ready;
   assign o_error         = r_error;
   assign o_retry_cnt     = r_retryCnt;
   assign o_state         = r_state;

endmodule

// File: tb/tb_ddr3_bringup_sequencer.sv
// Self-checking bench for ddr3_bringup_sequencer: expected outputs come from event-time arithmetic per attempt.
// Checks o_fail_cause when DDR3_BRINGUP_FAIL_CAUSE_EN is defined.
`timescale 1ns/1ps
module tb_ddr3_bringup_sequencer;

   localparam int POR  = 10;
   localparam int TO   = 100;
   localparam int MAXR = 2;
   localparam int NS   = 3;
   localparam int GAP  = 4;
   localparam int LAST = (NS - 1) * GAP;
   localparam int SYNC = 3;
   localparam int NEVER = 100000;

   logic          rclk = 1'b0;
   logic          resetN;
   logic          pllLocked;
   logic          initDone;
   logic          calSuccess;
   logic          calFail;
   logic          rearm;
   logic          emifResetN;
   logic [NS-1:0] stageResetN;
   logic          ready;
   logic          errorOut;
   logic [1:0]    retryCnt;
   logic [2:0]    state;
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
   logic [1:0]    failCause;
`endif

   int nChecks  = 0;
   int nErrors  = 0;
   int expRetry = 0;

   ddr3_bringup_sequencer #(
      .POR_CYCLES (POR),
      .CAL_TIMEOUT(TO),
      .MAX_RETRIES(MAXR),
      .N_STAGES   (NS),
      .STAGE_GAP  (GAP)
   ) dut (
      .i_rclk         (rclk),
      .i_reset_n      (resetN),
      .i_pll_locked   (pllLocked),
      .i_init_done    (initDone),
      .i_cal_success  (calSuccess),
      .i_cal_fail     (calFail),
      .i_rearm        (rearm),
      .o_emif_reset_n (emifResetN),
      .o_stage_reset_n(stageResetN),
      .o_ready        (ready),
      .o_error        (errorOut),
      .o_retry_cnt    (retryCnt),
      .o_state        (state)
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
      ,
      .o_fail_cause   (failCause)
`endif
   );

   always #25 rclk = ~rclk;

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nErrors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input int st, input int emif, input int stg, input int rdy, input int err);
      checkOutput({tag, ".state"}, 32'(state), st);
      checkOutput({tag, ".emif"}, 32'(emifResetN), emif);
      checkOutput({tag, ".stage"}, 32'(stageResetN), stg);
      checkOutput({tag, ".ready"}, 32'(ready), rdy);
      checkOutput({tag, ".error"}, 32'(errorOut), err);
      checkOutput({tag, ".retry"}, 32'(retryCnt), expRetry);
   endtask

   // One attempt measured from its POR entry edge (edge 0). Raw inputs rise just after edge lockAt/calAt;
   // a negative value means the input is already high and settled. The FSM reacts SYNC edges after a raw change.
   task automatic applyStimulus(input string tag, input int lockAt, input int calAt, input bit withFail, input bit stopEarly);
      int c, r, failT, endT, expSt, expEmif, expStg, expRdy;
      bit success;
      c = (lockAt + SYNC > POR + 1) ? lockAt + SYNC : POR + 1;
      r = (calAt + SYNC > c + 1) ? calAt + SYNC : c + 1;
      failT = 0;
      if (c > POR + TO || r > POR + TO) failT = POR + TO;
      else if (withFail) failT = r;
      success = (failT == 0);
      endT = success ? (stopEarly ? r + 1 : r + 1 + LAST) : failT;
      for (int e = 1; e <= endT; e++) begin
         if (e - 1 == lockAt) pllLocked = 1'b1;
         if (e - 1 == calAt) begin
            initDone   = 1'b1;
            calSuccess = 1'b1;
            calFail    = withFail;
         end
         tick();
         expEmif = 1; expStg = 0; expRdy = 0;
         if (e == failT) begin
            expSt = 5; expEmif = 0;
         end else if (e < POR) begin
            expSt = 0; expEmif = 0;
         end else if (e < c) begin
            expSt = 1;
         end else if (e < r) begin
            expSt = 2;
         end else if (e < r + 1 + LAST) begin
            expSt = 3;
            for (int k = 0; k < NS; k++)
               if (r + 1 + k * GAP <= e) expStg = expStg | (1 << k);
         end else begin
            expSt = 4; expStg = (1 << NS) - 1; expRdy = 1;
         end
         checkState($sformatf("%s.e%0d", tag, e), expSt, expEmif, expStg, expRdy, 0);
      end
      if (!success) begin
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
         checkOutput({tag, ".cause"}, 32'(failCause), withFail ? 2 : 1);
`endif
         tick();
         if (expRetry < MAXR) begin
            expRetry++;
            checkState({tag, ".retry"}, 0, 0, 0, 0, 0);
         end else begin
            checkState({tag, ".error"}, 6, 0, 0, 0, 1);
         end
      end
   endtask

   // Drops lock while in RUN; FAIL must appear on the third edge and POR on the fourth.
   task automatic applyLockLoss(input string tag);
      int n;
      n = $urandom_range(1, 8);
      repeat (n) begin
         tick();
         checkState({tag, ".run"}, 4, 1, 7, 1, 0);
      end
      pllLocked = 1'b0;
      tick(); checkState({tag, ".sync1"}, 4, 1, 7, 1, 0);
      tick(); checkState({tag, ".sync2"}, 4, 1, 7, 1, 0);
      tick(); checkState({tag, ".fail"}, 5, 0, 0, 0, 0);
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
      checkOutput({tag, ".cause"}, 32'(failCause), 3);
`endif
      tick();
      expRetry++;
      checkState({tag, ".por"}, 0, 0, 0, 0, 0);
   endtask

   task automatic applyReset(input string tag, input int cycles);
      resetN = 1'b0;
      repeat (cycles) tick();
      expRetry = 0;
      checkState(tag, 0, 0, 0, 0, 0);
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
      checkOutput({tag, ".cause"}, 32'(failCause), 0);
`endif
   endtask

   // Directed scenario sequence with randomised input timing.
   initial begin
      resetN = 1'b0; pllLocked = 1'b0; initDone = 1'b0; calSuccess = 1'b0; calFail = 1'b0; rearm = 1'b0;
      repeat (3) begin
         pllLocked = 1'($urandom); initDone = 1'($urandom); calSuccess = 1'($urandom); calFail = 1'($urandom);
         rearm = 1'($urandom);
         tick();
      end
      pllLocked = 1'b0; initDone = 1'b0; calSuccess = 1'b0; calFail = 1'b0; rearm = 1'b0;
      applyReset("reset", 2);
      resetN = 1'b1;
      applyStimulus("clean", 15, 40, 1'b0, 1'b0);

      rearm = 1'b1;
      tick();
      rearm = 1'b0;
      checkState("rearmInRun0", 4, 1, 7, 1, 0);
      tick();
      checkState("rearmInRun1", 4, 1, 7, 1, 0);

      applyLockLoss("lockLoss1");
      applyStimulus("relock1", $urandom_range(0, 20), -1, 1'b0, 1'b0);
      applyLockLoss("lockLoss2");
      applyStimulus("relock2", $urandom_range(0, 20), -1, 1'b0, 1'b1);
      applyReset("midRelease", 1);

      initDone = 1'b0; calSuccess = 1'b0;
      tick();
      resetN = 1'b1;
      applyStimulus("simul", -1, $urandom_range(0, 30), 1'b1, 1'b0);

      calFail = 1'b0; initDone = 1'b0; calSuccess = 1'b0; pllLocked = 1'b0;
      applyReset("preTimeout", 2);
      resetN = 1'b1;
      applyStimulus("tmo1", $urandom_range(0, 40), NEVER, 1'b0, 1'b0);
      applyStimulus("tmo2", -1, NEVER, 1'b0, 1'b0);
      applyStimulus("tmo3", -1, NEVER, 1'b0, 1'b0);

      repeat ($urandom_range(2, 6)) begin
         tick();
         checkState("errHold", 6, 0, 0, 0, 1);
      end

      rearm = 1'b1;
      tick();
      rearm = 1'b0;
      expRetry = 0;
      checkState("rearm", 0, 0, 0, 0, 0);
`ifdef DDR3_BRINGUP_FAIL_CAUSE_EN
      checkOutput("rearm.cause", 32'(failCause), 0);
`endif
      applyStimulus("afterRearm", -1, $urandom_range(0, 30), 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
